cereal_rx: RTL and testbench
============================

Name: cereal_rx

Overview:
- Asynchronous serial receiver; the receive end of the cereal line (idle-high, 1 start bit low, 8 data bits LSB first, 1 stop bit high).
- Oversamples the line using a one-clk-wide `pulse` tick from the shared baud/tick generator, at OVERSAMPLE ticks per bit.
- Validates the start and stop bits, then presents each received byte with a one-cycle `valid` strobe to downstream logic.

Parameters:
- OVERSAMPLE, 16, ticks of `pulse` per bit period. Must be even and >= 4.
- CW, $clog2(OVERSAMPLE), width of the tick counter. Derived; do not override.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- pulse  input  1  oversample tick, high for exactly one clk per tick.
- cereal  input  1  serial line, asynchronous to clk.
- data  output  8  last correctly framed byte; held until the next good frame.
- valid  output  1  one-clk strobe: `data` has just been updated.
- frame_err  output  1  one-clk strobe: stop bit was sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: async on rst_n low; all state is cleared regardless of frame progress.
  - sync flops = 1, state = IDLE, counters = 0, shift register = 0.
  - data = 8'h00, valid = 0, frame_err = 0, busy = 0.
- Synchroniser: 2-flop synchroniser on `cereal`; its output `rx` is the only signal the FSM reads.
- All FSM advancement and counting happen only on clks where pulse = 1. With pulse = 0 the state and counters hold.
- valid and frame_err default to 0 on every clk.
- IDLE:
  - On a pulse with rx = 0: go to START, tick counter = 0.
- START:
  - On each pulse, increment the counter.
  - On the pulse where the counter reaches OVERSAMPLE/2 - 1 (mid start bit), sample rx:
    - rx = 0: go to DATA, tick counter = 0, bit counter = 0.
    - rx = 1: glitch; return to IDLE with no strobe.
- DATA:
  - On each pulse, increment the counter.
  - On the pulse where the counter reaches OVERSAMPLE - 1, sample rx:
    - Shift rx into the MSB of the shift register (shift right).
    - Tick counter = 0, increment the bit counter.
  - After the 8th sample (bit counter reaches 7 and is sampled): go to STOP.
  - Result: the first bit received lands in shift[0].
- STOP:
  - Sample rx at the same OVERSAMPLE - 1 point.
  - rx = 1: on the next clk, data = shift register and valid = 1; go to IDLE.
  - rx = 0: on the next clk, frame_err = 1 and data is unchanged; go to BREAK.
- BREAK:
  - Wait for a pulse with rx = 1, then go to IDLE.
  - Prevents a held-low line (break) from being decoded as back-to-back 0x00 frames.
- Latency: valid or frame_err rises on the clk edge immediately after the clk carrying the stop-sample pulse.
- Back-to-back frames: a start bit beginning right after the stop bit is detected normally. IDLE re-arms on the first pulse after STOP.
- valid and frame_err are never both high. Each is exactly 1 clk wide.
- rx changing on a clk with pulse = 0 has no effect until the next pulse.

Test Plan:
- Normal frame (OVERSAMPLE = 16, pulse every 4 clk): drive 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 pulses/bit.
  - Required: data = 0xA5, valid high exactly 1 clk, frame_err = 0, busy low afterwards.
- Start glitch: line low for 4 pulses then high.
  - Required: no valid, no frame_err, back in IDLE (busy = 0) by the 8th pulse.
- Framing error then break: send 0x3C with stop bit low, after a previous good byte 0x11.
  - Required: frame_err 1 clk, valid = 0, data stays 0x11.
  - Then hold the line low for 40 bit times: no strobes, busy stays 1. Release high: IDLE.
- Back-to-back frames: 0x00 then 0xFF with no idle gap.
  - Required: two valid strobes, data = 0x00 then 0xFF, ~160 pulses apart.
- Reset mid-frame: assert rst_n low during bit 4 of 0x5A, release, then send 0xC3.
  - Required: outputs are at reset values immediately with no clk edge needed; only the 0xC3 valid strobe is seen.
- Pulse stall: hold pulse = 0 for 50 clk during bit 2 of 0x96, then resume.
  - Required: data = 0x96, valid once.

Source files
------------

// File: rtl/cereal_rx.sv
// cereal_rx: oversampling 8N1 serial receiver with start/stop validation and break handling
`timescale 1ns/1ps
module cereal_rx #(
  parameter int OVERSAMPLE = 16,
  localparam int CW = $clog2(OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pulse,
  input  logic       cereal,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t          state_q;
  logic [1:0]      sync_q;
  logic [CW-1:0]   tick_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            rx, tick_mid, tick_last;
  assign rx        = sync_q[1];
  assign tick_mid  = tick_q == CW'(OVERSAMPLE/2 - 1);
  assign tick_last = tick_q == CW'(OVERSAMPLE - 1);
  assign busy      = state_q != IDLE;
  // Synchronise the line, then step the frame FSM once per oversample tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], cereal};
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (pulse) begin
        case (state_q)
          IDLE: if (!rx) begin
            state_q <= START;
            tick_q  <= '0;
          end
          START: if (tick_mid) begin
            state_q <= rx ? IDLE : DATA;
            tick_q  <= '0;
            bit_q   <= '0;
          end else tick_q <= tick_q + 1'b1;
          DATA: if (tick_last) begin
            shift_q <= {rx, shift_q[7:1]};
            tick_q  <= '0;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else tick_q <= tick_q + 1'b1;
          STOP: if (tick_last) begin
            tick_q <= '0;
            if (rx) begin
              data    <= shift_q;
              valid   <= 1'b1;
              state_q <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state_q   <= BRK;
            end
          end else tick_q <= tick_q + 1'b1;
          BRK: if (rx) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cereal_rx.sv
// tb_cereal_rx: directed self-checking bench for cereal_rx
`timescale 1ns/1ps
module tb_cereal_rx;
  logic       clk = 1'b0, rst_n = 1'b0, pulse = 1'b0, cereal = 1'b1, en = 1'b1;
  logic [1:0] pdiv = 2'd0;
  logic [7:0] data;
  logic       valid, frame_err, busy;
  int checks = 0, errors = 0;
  int pcnt = 0, vcount = 0, fcount = 0, both = 0, vp0 = 0, vp1 = 0;
  int v0, vr;
  logic [7:0] d;

  cereal_rx #(.OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .cereal(cereal),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // one pulse every 4 clk, gated by en for the stall test
  always @(negedge clk) begin
    pdiv  = pdiv + 2'd1;
    pulse = en && (pdiv == 2'd0);
  end

  always @(posedge clk) if (pulse) pcnt++;

  // strobe monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      vp1 = vp0;
      vp0 = pcnt;
    end
    if (frame_err) fcount++;
    if (valid && frame_err) both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulses(input int n);
    int t;
    t = pcnt + n;
    while (pcnt < t) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    cereal = b;
    wait_pulses(16);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(s);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_pulses(20);
    chk("idle_busy", busy, 1'b0);

    v0 = vcount;
    send_frame(8'hA5, 1'b1);
    chk("a5_vcount", vcount, v0 + 1);
    chk("a5_data", data, 8'hA5);
    chk("a5_ferr", fcount, 0);
    chk("a5_busy", busy, 1'b0);

    v0 = vcount;
    cereal = 1'b0;
    wait_pulses(4);
    chk("glitch_busy_mid", busy, 1'b1);
    cereal = 1'b1;
    wait_pulses(12);
    chk("glitch_busy", busy, 1'b0);
    chk("glitch_vcount", vcount, v0);
    chk("glitch_ferr", fcount, 0);

    send_frame(8'h11, 1'b1);
    chk("11_data", data, 8'h11);
    v0 = vcount;
    send_frame(8'h3C, 1'b0);
    chk("fe_count", fcount, 1);
    chk("fe_vcount", vcount, v0);
    chk("fe_data", data, 8'h11);
    chk("fe_busy", busy, 1'b1);
    wait_pulses(40 * 16);
    chk("brk_fcount", fcount, 1);
    chk("brk_vcount", vcount, v0);
    chk("brk_busy", busy, 1'b1);
    cereal = 1'b1;
    wait_pulses(16);
    chk("brk_release", busy, 1'b0);

    v0 = vcount;
    send_frame(8'h00, 1'b1);
    chk("b2b_data0", data, 8'h00);
    send_frame(8'hFF, 1'b1);
    chk("b2b_vcount", vcount, v0 + 2);
    chk("b2b_data1", data, 8'hFF);
    chk("b2b_spacing", vp0 - vp1, 160);

    v0 = vcount;
    d = 8'h96;
    send_bit(1'b0);
    send_bit(d[0]);
    send_bit(d[1]);
    cereal = d[2];
    wait_pulses(8);
    en = 1'b0;
    repeat (50) @(negedge clk);
    en = 1'b1;
    wait_pulses(8);
    for (int i = 3; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    chk("stall_vcount", vcount, v0 + 1);
    chk("stall_data", data, 8'h96);

    vr = vcount;
    d = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    cereal = d[4];
    wait_pulses(8);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_ferr", frame_err, 1'b0);
    cereal = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_pulses(32);
    send_frame(8'hC3, 1'b1);
    chk("c3_vcount", vcount, vr + 1);
    chk("c3_data", data, 8'hC3);
    chk("never_both", both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
